// File: rtl/key_emu_pkg.sv
// Shared types and constants for the key bounce emulator.
// Optional macro: KEY_EMU_BOUNCE_EN (LFSR-driven contact bounce).
package key_emu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAKE_BOUNCE,
    HOLD,
    BREAK_BOUNCE
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 seen from the right-shifting end: bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, advanced one step per enabled clock.
// Used by key_bounce_emulator when KEY_EMU_BOUNCE_EN is defined.
module lfsr16
  import key_emu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) state_d = lfsr_step(state_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= LFSR_SEED;
    else         state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/key_bounce_emulator.sv
// Emulates bouncy key presses on a pad bus (make / hold / break).
// Optional macro: KEY_EMU_BOUNCE_EN; undefined gives clean edges.
module key_bounce_emulator #(
  parameter int   KEY_NUM    = 2,
  parameter int   BOUNCE_CYC = 250000,
  parameter int   HOLD_CYC   = 500000,
  parameter int   TOGGLE_DIV = 1000,
  parameter logic ACTIVE_LVL = 1'b1
) (
  input  logic               Sys_CLK,
  input  logic               Sys_RST_N,
  input  logic               Press_Req,
  input  logic [KEY_NUM-1:0] Key_Sel,
  output logic               Busy,
  output logic               Done,
  output logic [KEY_NUM-1:0] Key_Pad
);
  import key_emu_pkg::*;

  localparam int PH_MAX = (BOUNCE_CYC > HOLD_CYC) ? BOUNCE_CYC
                                                  : HOLD_CYC;
  localparam int PH_W = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TK_W = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;

  localparam logic [KEY_NUM-1:0] IDLE_PAD = {KEY_NUM{~ACTIVE_LVL}};

  state_e             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [TK_W-1:0]    tick_q,  tick_d;
  logic [KEY_NUM-1:0] sel_q,   sel_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [KEY_NUM-1:0] pad_q,   pad_d;
  logic               tick_wrap;
  logic               lvl;

  assign tick_wrap = (tick_q == TK_W'(TOGGLE_DIV - 1));

`ifdef KEY_EMU_BOUNCE_EN
  logic        lfsr_en;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_nx;

  assign lfsr_en = ((state_q == MAKE_BOUNCE) ||
                    (state_q == BREAK_BOUNCE)) && tick_wrap;

  lfsr16 u_lfsr (
    .clk_i   (Sys_CLK),
    .rst_ni  (Sys_RST_N),
    .en_i    (lfsr_en),
    .state_o (lfsr_q)
  );

  // Pad is registered, so look one step ahead to stay in phase.
  assign lfsr_nx = lfsr_en ? lfsr_step(lfsr_q) : lfsr_q;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + PH_W'(1);
    tick_d  = tick_wrap ? '0 : tick_q + TK_W'(1);
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        tick_d  = '0;
        busy_d  = 1'b0;
        if (Press_Req && (|Key_Sel)) begin
          sel_d   = Key_Sel;
          state_d = MAKE_BOUNCE;
          busy_d  = 1'b1;
        end
      end
      MAKE_BOUNCE: begin
        if (phase_q == PH_W'(BOUNCE_CYC - 1)) begin
          state_d = HOLD;
          phase_d = '0;
          tick_d  = '0;
        end
      end
      HOLD: begin
        tick_d = '0;
        if (phase_q == PH_W'(HOLD_CYC - 1)) begin
          state_d = BREAK_BOUNCE;
          phase_d = '0;
        end
      end
      BREAK_BOUNCE: begin
        if (phase_q == PH_W'(BOUNCE_CYC - 1)) begin
          state_d = IDLE;
          phase_d = '0;
          tick_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lvl = ~ACTIVE_LVL;
    case (state_d)
`ifdef KEY_EMU_BOUNCE_EN
      MAKE_BOUNCE,
      BREAK_BOUNCE: lvl = lfsr_nx[0] ? ACTIVE_LVL : ~ACTIVE_LVL;
      HOLD:         lvl = ACTIVE_LVL;
`else
      MAKE_BOUNCE,
      HOLD:         lvl = ACTIVE_LVL;
`endif
      default:      lvl = ~ACTIVE_LVL;
    endcase
    pad_d = (sel_d & {KEY_NUM{lvl}}) | (~sel_d & IDLE_PAD);
  end

  always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
    if (!Sys_RST_N) begin
      state_q <= IDLE;
      phase_q <= '0;
      tick_q  <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pad_q   <= IDLE_PAD;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pad_q   <= pad_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Key_Pad = pad_q;

endmodule

// File: tb/tb_key_bounce_emulator.sv
// Scoreboard bench for key_bounce_emulator (active-high and active-low).
// Works with or without KEY_EMU_BOUNCE_EN.
module tb_key_bounce_emulator;

  localparam int BC = 100;
  localparam int HC = 200;
  localparam int TD = 4;
  localparam int NB = 2 * BC / TD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [1:0] sel0 = 2'b00;
  logic [1:0] sel1 = 2'b00;
  logic       busy0, done0, busy1, done1;
  logic [1:0] pad0, pad1;

  always #10 clk = ~clk;

  key_bounce_emulator #(
    .KEY_NUM(2), .BOUNCE_CYC(BC), .HOLD_CYC(HC),
    .TOGGLE_DIV(TD), .ACTIVE_LVL(1'b1)
  ) u0 (
    .Sys_CLK(clk), .Sys_RST_N(rst_n), .Press_Req(req0),
    .Key_Sel(sel0), .Busy(busy0), .Done(done0), .Key_Pad(pad0)
  );

  key_bounce_emulator #(
    .KEY_NUM(2), .BOUNCE_CYC(BC), .HOLD_CYC(HC),
    .TOGGLE_DIV(TD), .ACTIVE_LVL(1'b0)
  ) u1 (
    .Sys_CLK(clk), .Sys_RST_N(rst_n), .Press_Req(req1),
    .Key_Sel(sel1), .Busy(busy1), .Done(done1), .Key_Pad(pad1)
  );

  logic [3:0]  q0[$];
  logic [3:0]  q1[$];
  logic [15:0] m0 = 16'hACE1;
  logic [15:0] m1 = 16'hACE1;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [3:0]  e0, e1;

  function automatic logic [15:0] step(input logic [15:0] s);
    int v, b;
    v = int'(s);
    b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  task automatic check(input string name, input logic [3:0] got,
                       input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  // Expected per-cycle {Busy,Done,Key_Pad} for an accepted press.
  task automatic push_press(input int which, input logic [1:0] sel);
    logic        act, lvl;
    logic [1:0]  idle, pad;
    logic [15:0] l;
    logic        bits [0:NB-1];
    act  = (which == 0);
    idle = {~act, ~act};
    l    = (which == 0) ? m0 : m1;
    for (int i = 0; i < NB; i++) begin
      bits[i] = l[0];
      l = step(l);
    end
    for (int t = 0; t < 2 * BC + HC; t++) begin
`ifdef KEY_EMU_BOUNCE_EN
      if (t < BC)           lvl = bits[t / TD] ? act : ~act;
      else if (t < BC + HC) lvl = act;
      else lvl = bits[BC / TD + (t - BC - HC) / TD] ? act : ~act;
`else
      lvl = (t < BC + HC) ? act : ~act;
`endif
      pad = (sel & {2{lvl}}) | (~sel & idle);
      if (which == 0) q0.push_back({2'b10, pad});
      else            q1.push_back({2'b10, pad});
    end
    if (which == 0) begin
      q0.push_back({2'b01, idle});
      m0 = l;
    end else begin
      q1.push_back({2'b01, idle});
      m1 = l;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    e0 = (q0.size() > 0) ? q0.pop_front() : 4'b0000;
    e1 = (q1.size() > 0) ? q1.pop_front() : 4'b0011;
    check("dut0", {busy0, done0, pad0}, e0);
    check("dut1", {busy1, done1, pad1}, e1);
  end

  // One-cycle request; inject>0 adds an ignored request mid-press.
  task automatic press(input int which, input logic [1:0] sel,
                       input int inject, input logic [1:0] isel);
    @(posedge clk); #2;
    if (which == 0) begin req0 = 1'b1; sel0 = sel; end
    else            begin req1 = 1'b1; sel1 = sel; end
    @(posedge clk); #2;
    req0 = 1'b0;
    req1 = 1'b0;
    if (sel != 2'b00) push_press(which, sel);
    if (inject > 0 && sel != 2'b00) begin
      repeat (inject) @(posedge clk);
      #2;
      if (which == 0) begin req0 = 1'b1; sel0 = isel; end
      else            begin req1 = 1'b1; sel1 = isel; end
      @(posedge clk); #2;
      req0 = 1'b0;
      req1 = 1'b0;
      sel0 = 2'(($urandom));
      sel1 = 2'(($urandom));
    end
  endtask

  task automatic wait_idle(input int gap);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout left0=%0d left1=%0d required=0",
               q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (gap) @(posedge clk);
  endtask

  initial begin
    int g, inj;
    logic [1:0] s;
    #5 rst_n = 1'b0;
    #40 rst_n = 1'b1;
    #1;
    check("reset0", {busy0, done0, pad0}, 4'b0000);
    check("reset1", {busy1, done1, pad1}, 4'b0011);
    repeat (3) @(posedge clk);

    press(0, 2'b01, 0, 2'b00);
    wait_idle(3);
    press(0, 2'b00, 0, 2'b00);
    wait_idle(10);
    press(0, 2'b01, 50, 2'b10);
    wait_idle(3);

    press(0, 2'b01, 0, 2'b00);
    repeat (149) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort0", {busy0, done0, pad0}, 4'b0000);
    check("abort1", {busy1, done1, pad1}, 4'b0011);
    q0.delete();
    q1.delete();
    m0 = 16'hACE1;
    m1 = 16'hACE1;
    #20 rst_n = 1'b1;
    repeat (BC + HC + BC + 10) @(posedge clk);

    press(1, 2'b11, 0, 2'b00);
    wait_idle(3);

    for (int i = 0; i < 8; i++) begin
      g   = $urandom_range(2, 6);
      s   = 2'($urandom_range(0, 3));
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 390) : 0;
      press(i % 2, s, inj, 2'($urandom_range(0, 3)));
      wait_idle(g);
    end

    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
